// File: rtl/bru_npc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bru_npc_pkg
// Description : Shared constants for the branch/next-PC unit: datapath width,
//               reset PC, conditional-branch funct3 codes and link registers.
// Revision    : 1.0 - initial release
// ============================================================================
package bru_npc_pkg;

    localparam int          c_cpu_width = 32;
    localparam logic [31:0] c_reset_pc  = 32'h8000_0000;

    // funct3 encodings of the RV32 conditional branches
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_funct_e;

    // Registers that act as link registers for return-address prediction
    localparam logic [4:0] c_link_x1 = 5'd1;
    localparam logic [4:0] c_link_x5 = 5'd5;

    function automatic logic is_link(input logic [4:0] idx);
        return (idx == c_link_x1) || (idx == c_link_x5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bru_ras.sv
`default_nettype none
// ============================================================================
// Module      : bru_ras
// Description : Circular return-address stack. A push onto a full stack
//               overwrites the oldest entry; a pop from an empty stack is
//               ignored; push and pop together replace the top entry.
// Revision    : 1.0 - initial release
// ============================================================================
module bru_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    input  wire logic            i_push,
    input  wire logic            i_pop,
    input  wire logic [XLEN-1:0] i_wdata,
    output logic      [XLEN-1:0] o_top,
    output logic                 o_valid
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w+1)'(DEPTH);

    logic [XLEN-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_ptr;      // next write slot; top lives at r_ptr-1
    logic [c_ptr_w:0]   r_count;    // live entries, saturates at DEPTH
    logic [c_ptr_w-1:0] w_top_idx;
    logic               w_empty;

    assign w_top_idx = r_ptr - 1'b1;
    assign w_empty   = (r_count == '0);
    assign o_valid   = ~w_empty;
    assign o_top     = w_empty ? '0 : r_mem[w_top_idx];

    // Stack pointer, occupancy and entry storage
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && i_pop && !w_empty) begin
            r_mem[w_top_idx] <= i_wdata;
        end else if (i_push) begin
            r_mem[r_ptr] <= i_wdata;
            r_ptr        <= r_ptr + 1'b1;
            if (r_count != c_full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_pop && !w_empty) begin
            r_ptr   <= r_ptr - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bru_npc.sv
`default_nettype none
// ============================================================================
// Module      : bru_npc
// Description : Branch/next-PC unit. Owns the PC, resolves conditional
//               branches and jal/jalr targets, detects misaligned targets
//               (sticky fault), drives a return-address stack and keeps
//               branch statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module bru_npc
    import bru_npc_pkg::*;
#(
    parameter int              XLEN      = c_cpu_width,
    parameter logic [XLEN-1:0] RESET_PC  = c_reset_pc,
    parameter int              RAS_DEPTH = 4,
    parameter int              CNT_W     = 32,
    parameter bit              IALIGN16  = 1'b0
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    input  wire logic             i_valid,
    input  wire logic             i_stall,
    input  wire logic             i_idu_jal,
    input  wire logic             i_idu_jalr,
    input  wire logic             i_idu_brch,
    input  wire logic [2:0]       i_funct3,
    input  wire logic [4:0]       i_rs1_idx,
    input  wire logic [4:0]       i_rd_idx,
    input  wire logic [XLEN-1:0]  i_rs1,
    input  wire logic [XLEN-1:0]  i_rs2,
    input  wire logic [XLEN-1:0]  i_imm,
    input  wire logic [XLEN-1:0]  i_alu_out,
    output logic      [XLEN-1:0]  o_pc,
    output logic      [XLEN-1:0]  o_next_pc,
    output logic                  o_taken,
    output logic                  o_misalign,
    output logic                  o_fault,
    output logic      [XLEN-1:0]  o_ras_pred,
    output logic                  o_ras_valid,
    output logic      [CNT_W-1:0] o_br_cnt,
    output logic      [CNT_W-1:0] o_br_taken_cnt,
    output logic      [CNT_W-1:0] o_ras_miss_cnt
);

    logic [XLEN-1:0]  r_pc;
    logic             r_fault;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_br_taken_cnt;
    logic [CNT_W-1:0] r_ras_miss_cnt;

    logic             w_is_jal, w_is_jalr, w_is_br;
    logic             w_br_cond;
    logic [XLEN-1:0]  w_seq, w_jalr_tgt, w_br_tgt, w_target;
    logic             w_en, w_upd;
    logic             w_push, w_pop, w_miss;

    // Decode flags are exclusive; priority still resolves jal > jalr > branch
    assign w_is_jal  = i_idu_jal;
    assign w_is_jalr = i_idu_jalr & ~i_idu_jal;
    assign w_is_br   = i_idu_brch & ~i_idu_jal & ~i_idu_jalr;

    assign w_seq      = r_pc + XLEN'(4);
    assign w_jalr_tgt = {i_alu_out[XLEN-1:1], 1'b0};
    assign w_br_tgt   = r_pc + i_imm;

    // Conditional-branch comparison; reserved funct3 codes never branch
    always_comb begin
        w_br_cond = 1'b0;
        case (i_funct3)
            BR_BEQ:  w_br_cond = (i_rs1 == i_rs2);
            BR_BNE:  w_br_cond = (i_rs1 != i_rs2);
            BR_BLT:  w_br_cond = ($signed(i_rs1) <  $signed(i_rs2));
            BR_BGE:  w_br_cond = ($signed(i_rs1) >= $signed(i_rs2));
            BR_BLTU: w_br_cond = (i_rs1 <  i_rs2);
            BR_BGEU: w_br_cond = (i_rs1 >= i_rs2);
            default: w_br_cond = 1'b0;
        endcase
    end

    // Target select and next-PC mux
    always_comb begin
        w_target = w_seq;
        o_taken  = 1'b0;
        if (w_is_jal) begin
            w_target = i_alu_out;
            o_taken  = 1'b1;
        end else if (w_is_jalr) begin
            w_target = w_jalr_tgt;
            o_taken  = 1'b1;
        end else if (w_is_br && w_br_cond) begin
            w_target = w_br_tgt;
            o_taken  = 1'b1;
        end
    end

    assign o_next_pc  = w_target;
    // jalr clears bit 0 itself, so only jal/branch can be odd
    assign o_misalign = o_taken &
                        ((~IALIGN16 & w_target[1]) | ((w_is_jal | w_is_br) & w_target[0]));

    assign w_en  = i_valid & ~i_stall & ~r_fault;
    assign w_upd = w_en & ~o_misalign;

    // A jalr that both links and returns through the same register is a call only
    assign w_push = w_upd & (w_is_jal | w_is_jalr) & is_link(i_rd_idx);
    assign w_pop  = w_upd & w_is_jalr & is_link(i_rs1_idx) &
                    ~(is_link(i_rd_idx) & (i_rs1_idx == i_rd_idx));
    assign w_miss = w_pop & (~o_ras_valid | (w_jalr_tgt != o_ras_pred));

    bru_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_seq),
        .o_top   (o_ras_pred),
        .o_valid (o_ras_valid)
    );

    // PC register and sticky misalign fault
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else if (w_en) begin
            if (o_misalign) begin
                r_fault <= 1'b1;
            end else begin
                r_pc <= o_next_pc;
            end
        end
    end

    // Branch and return-prediction statistics, frozen on a faulting cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_br_cnt       <= '0;
            r_br_taken_cnt <= '0;
            r_ras_miss_cnt <= '0;
        end else if (w_upd) begin
            if (w_is_br) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
            if (w_is_br && w_br_cond) begin
                r_br_taken_cnt <= r_br_taken_cnt + 1'b1;
            end
            if (w_miss) begin
                r_ras_miss_cnt <= r_ras_miss_cnt + 1'b1;
            end
        end
    end

    assign o_pc           = r_pc;
    assign o_fault        = r_fault;
    assign o_br_cnt       = r_br_cnt;
    assign o_br_taken_cnt = r_br_taken_cnt;
    assign o_ras_miss_cnt = r_ras_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bru_npc.sv
`default_nettype none
// ============================================================================
// Module      : tb_bru_npc
// Description : Directed scoreboard bench for bru_npc. Stimulus pushes
//               hand-computed expectations tagged with the cycle they apply
//               to; a monitor on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bru_npc;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, stall, jal, jalr, brch;
    logic [2:0]  funct3;
    logic [4:0]  rs1_idx, rd_idx;
    logic [31:0] rs1, rs2, imm, alu_out;
    logic [31:0] pc, next_pc, ras_pred, br_cnt, br_taken_cnt, ras_miss_cnt;
    logic        taken, misalign, fault, ras_valid;

    always #5 clk = ~clk;

    bru_npc dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_valid        (valid),
        .i_stall        (stall),
        .i_idu_jal      (jal),
        .i_idu_jalr     (jalr),
        .i_idu_brch     (brch),
        .i_funct3       (funct3),
        .i_rs1_idx      (rs1_idx),
        .i_rd_idx       (rd_idx),
        .i_rs1          (rs1),
        .i_rs2          (rs2),
        .i_imm          (imm),
        .i_alu_out      (alu_out),
        .o_pc           (pc),
        .o_next_pc      (next_pc),
        .o_taken        (taken),
        .o_misalign     (misalign),
        .o_fault        (fault),
        .o_ras_pred     (ras_pred),
        .o_ras_valid    (ras_valid),
        .o_br_cnt       (br_cnt),
        .o_br_taken_cnt (br_taken_cnt),
        .o_ras_miss_cnt (ras_miss_cnt)
    );

    typedef struct {
        int          cyc;
        bit          comb;
        logic [31:0] npc;
        logic        tk, mis;
        logic [31:0] pc;
        logic        flt, rv;
        logic [31:0] rp, brc, tkc, msc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [31:0] e_pc, e_rp, e_br, e_tk, e_miss;
    logic        e_flt, e_rv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every expectation tagged for the current cycle
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL stale_entry: got cycle %0d expected cycle %0d", cyc, e.cyc);
            end else if (e.comb) begin
                chk("next_pc",  next_pc,         e.npc);
                chk("taken",    {31'b0, taken},    {31'b0, e.tk});
                chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
            end else begin
                chk("pc",        pc,                 e.pc);
                chk("fault",     {31'b0, fault},     {31'b0, e.flt});
                chk("ras_valid", {31'b0, ras_valid}, {31'b0, e.rv});
                chk("ras_pred",  ras_pred,           e.rp);
                chk("br_cnt",    br_cnt,             e.brc);
                chk("taken_cnt", br_taken_cnt,       e.tkc);
                chk("miss_cnt",  ras_miss_cnt,       e.msc);
            end
        end
    end

    task automatic push_state(input int at);
        exp_t e;
        e = '{cyc: at, comb: 1'b0, npc: '0, tk: 1'b0, mis: 1'b0, pc: e_pc, flt: e_flt,
              rv: e_rv, rp: e_rp, brc: e_br, tkc: e_tk, msc: e_miss};
        q.push_back(e);
    endtask

    task automatic set_in(input bit v, input bit s, input bit j, input bit jr, input bit b,
                          input logic [2:0] f3, input logic [4:0] r1i, input logic [4:0] rdi,
                          input logic [31:0] a, input logic [31:0] c, input logic [31:0] im,
                          input logic [31:0] alu);
        valid = v; stall = s; jal = j; jalr = jr; brch = b; funct3 = f3;
        rs1_idx = r1i; rd_idx = rdi; rs1 = a; rs2 = c; imm = im; alu_out = alu;
    endtask

    // Expect comb outputs this cycle and the e_* state after the next edge
    task automatic step(input logic [31:0] npc, input bit tk, input bit mis);
        exp_t e;
        e = '{cyc: cyc, comb: 1'b1, npc: npc, tk: tk, mis: mis, pc: '0, flt: 1'b0,
              rv: 1'b0, rp: '0, brc: '0, tkc: '0, msc: '0};
        q.push_back(e);
        push_state(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit with_stall);
        rst = 1'b1;
        set_in(with_stall, with_stall, 1'b0, 1'b0, 1'b1, 3'b000, 5'd0, 5'd0,
               32'd1, 32'd1, 32'h40, 32'd0);
        e_pc = 32'h8000_0000; e_flt = 1'b0; e_rv = 1'b0; e_rp = '0;
        e_br = '0; e_tk = '0; e_miss = '0;
        push_state(cyc + 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rets [4];
        logic [31:0] p;
        rets[0] = 32'h8000_0508; rets[1] = 32'h8000_0408;
        rets[2] = 32'h8000_0308; rets[3] = 32'h8000_0208;

        do_reset(1'b0);

        // invalid slot holds everything
        set_in(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        step(32'h8000_0004, 0, 0);

        // three sequential retirements
        for (int i = 1; i <= 3; i++) begin
            set_in(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
            e_pc = 32'h8000_0000 + 32'(4 * i);
            step(e_pc, 0, 0);
        end

        // conditional branches from 0x80000000
        do_reset(1'b0);
        set_in(1, 0, 0, 0, 1, 3'b000, 0, 0, 32'd5, 32'd5, 32'h10, 0);          // beq taken
        e_pc = 32'h8000_0010; e_br = 1; e_tk = 1; step(e_pc, 1, 0);
        set_in(1, 0, 0, 0, 1, 3'b110, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h20, 0);  // bltu not taken
        e_pc = 32'h8000_0014; e_br = 2; step(e_pc, 0, 0);
        set_in(1, 0, 0, 0, 1, 3'b100, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h20, 0);  // blt taken
        e_pc = 32'h8000_0034; e_br = 3; e_tk = 2; step(e_pc, 1, 0);
        set_in(1, 0, 0, 0, 1, 3'b111, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 0); // bgeu back
        e_pc = 32'h8000_0030; e_br = 4; e_tk = 3; step(e_pc, 1, 0);
        set_in(1, 0, 0, 0, 1, 3'b010, 0, 0, 32'd7, 32'd7, 32'h8, 0);          // reserved code
        e_pc = 32'h8000_0034; e_br = 5; step(e_pc, 0, 0);
        set_in(1, 0, 0, 0, 1, 3'b001, 0, 0, 32'd3, 32'd3, 32'h8, 0);          // bne not taken
        e_pc = 32'h8000_0038; e_br = 6; step(e_pc, 0, 0);
        set_in(1, 0, 0, 0, 1, 3'b101, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'h8, 0);  // bge taken
        e_pc = 32'h8000_0040; e_br = 7; e_tk = 4; step(e_pc, 1, 0);

        // jal without link, call, matching return
        set_in(1, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'h8000_0100);
        e_pc = 32'h8000_0100; step(e_pc, 1, 0);
        set_in(1, 0, 1, 0, 0, 3'b000, 0, 1, 0, 0, 0, 32'h8000_0200);
        e_pc = 32'h8000_0200; e_rv = 1; e_rp = 32'h8000_0104; step(e_pc, 1, 0);
        set_in(1, 0, 0, 1, 0, 3'b000, 1, 0, 0, 0, 0, 32'h8000_0104);
        e_pc = 32'h8000_0104; e_rv = 0; e_rp = 0; step(e_pc, 1, 0);

        // five calls into a 4-deep stack, alternating x1/x5 links
        for (int k = 0; k < 5; k++) begin
            p = 32'h8000_0104 + 32'(k * 32'h100);
            set_in(1, 0, 1, 0, 0, 3'b000, 0, (k % 2 == 1) ? 5'd5 : 5'd1, 0, 0, 0, p + 32'h100);
            e_pc = p + 32'h100; e_rv = 1; e_rp = p + 32'd4; step(e_pc, 1, 0);
        end
        for (int j = 0; j < 4; j++) begin
            set_in(1, 0, 0, 1, 0, 3'b000, 1, 0, 0, 0, 0, rets[j]);
            e_pc = rets[j]; e_rv = (j < 3); e_rp = (j < 3) ? rets[j + 1] : 32'd0;
            step(e_pc, 1, 0);
        end
        set_in(1, 0, 0, 1, 0, 3'b000, 1, 0, 0, 0, 0, 32'h8000_0108);          // pop on empty
        e_pc = 32'h8000_0108; e_miss = 1; step(e_pc, 1, 0);

        // call, then pop+push with different links, then same-link jalr (push only)
        set_in(1, 0, 1, 0, 0, 3'b000, 0, 1, 0, 0, 0, 32'h8000_0300);
        e_pc = 32'h8000_0300; e_rv = 1; e_rp = 32'h8000_010C; step(e_pc, 1, 0);
        set_in(1, 0, 0, 1, 0, 3'b000, 1, 5, 0, 0, 0, 32'h8000_0400);
        e_pc = 32'h8000_0400; e_rp = 32'h8000_0304; e_miss = 2; step(e_pc, 1, 0);
        set_in(1, 0, 0, 1, 0, 3'b000, 1, 1, 0, 0, 0, 32'h8000_0500);
        e_pc = 32'h8000_0500; e_rp = 32'h8000_0404; step(e_pc, 1, 0);

        // stalled taken branch holds state, then redirects once
        for (int s = 0; s < 2; s++) begin
            set_in(1, 1, 0, 0, 1, 3'b000, 0, 0, 32'd9, 32'd9, 32'h40, 0);
            step(32'h8000_0540, 1, 0);
        end
        set_in(1, 0, 0, 0, 1, 3'b000, 0, 0, 32'd9, 32'd9, 32'h40, 0);
        e_pc = 32'h8000_0540; e_br = 8; e_tk = 5; step(e_pc, 1, 0);
        set_in(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        e_pc = 32'h8000_0544; step(e_pc, 0, 0);

        // misaligned jalr target raises the sticky fault and freezes the unit
        set_in(1, 0, 0, 1, 0, 3'b000, 2, 0, 0, 0, 0, 32'h8000_0006);
        e_flt = 1; step(32'h8000_0006, 1, 1);
        set_in(1, 0, 0, 0, 1, 3'b000, 0, 0, 32'd4, 32'd4, 32'h8, 0);
        step(32'h8000_054C, 1, 0);
        set_in(1, 0, 1, 0, 0, 3'b000, 0, 1, 0, 0, 0, 32'h8000_0800);
        step(32'h8000_0800, 1, 0);

        // reset while stalled and faulted
        do_reset(1'b1);

        // jalr with odd target is legal once bit 0 is cleared
        set_in(1, 0, 0, 1, 0, 3'b000, 2, 0, 0, 0, 0, 32'h8000_0011);
        e_pc = 32'h8000_0010; step(e_pc, 1, 0);
        // not-taken branch with odd offset never misaligns
        set_in(1, 0, 0, 0, 1, 3'b000, 0, 0, 32'd1, 32'd2, 32'h3, 0);
        e_pc = 32'h8000_0014; e_br = 1; step(e_pc, 0, 0);
        // taken branch to odd address faults, no counter update
        set_in(1, 0, 0, 0, 1, 3'b000, 0, 0, 32'd6, 32'd6, 32'h11, 0);
        e_flt = 1; step(32'h8000_0025, 1, 1);

        do_reset(1'b0);
        set_in(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
